cic8_interp: RTL and testbench

Third-order CIC interpolator (R=8, M=1) for the sigma-delta music box. It sits after the halfband stages, which run from the same 640-cycle schedule. It takes one 16-bit signed sample per eight output strobes from the second halfband filter and produces a unity-gain 16-bit stream at the `enb_cic8` rate (one strobe every 20 clk at 46.305 MHz) for the sigma-delta modulator.

---
 rtl/cic8_pkg.sv | 34 +++
 rtl/cic_comb_stage.sv | 31 +++
 rtl/cic8_interp.sv | 93 +++++++++
 tb/tb_cic8_interp.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cic8_pkg.sv
// Shared parameters, types and output saturation for the R=8 CIC interpolator.
//   N     : number of comb/integrator stages
//   R     : interpolation ratio
//   DW    : input/output sample width (two's complement)
//   GW    : internal comb/integrator width, DW + N*log2(R)
//   SHIFT : output arithmetic right shift, log2((R*M)^N / R)
package cic8_pkg;

  localparam int unsigned N     = 3;
  localparam int unsigned R     = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned GW    = 25;
  localparam int unsigned SHIFT = 6;
  localparam int unsigned PW    = 3;   // phase counter width, log2(R)

  typedef logic signed [DW-1:0] sample_t;
  typedef logic signed [GW-1:0] acc_t;

  // Scale the integrator output back to unity gain and clamp to DW bits.
  // The clamp only engages on illegal input; it keeps a wrap from turning
  // into a full-scale sign flip at the modulator.
  function automatic sample_t sat_dw(input acc_t v);
    acc_t s;
    s = v >>> SHIFT;
    if ((&s[GW-1:DW-1]) || (~|s[GW-1:DW-1])) begin
      return sample_t'(s[DW-1:0]);
    end else if (s[GW-1]) begin
      return sample_t'({1'b1, {(DW-1){1'b0}}});
    end else begin
      return sample_t'({1'b0, {(DW-1){1'b1}}});
    end
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb section: y_c = x - x_delayed, with the delay register loaded only
// when the low-rate sample advances.
//   clk, rst_n : clock, async active-low reset
//   load       : advance the delay register with x
//   x          : stage input (GW bits, modular)
//   y_c        : combinational difference output
module cic_comb_stage
  import cic8_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  acc_t x,
  output acc_t y_c
);

  acc_t d;

  // Difference against the previous low-rate value (wraps modulo 2^GW).
  assign y_c = x - d;

  // Delay register, advanced once per input sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d <= '0;
    end else if (load) begin
      d <= x;
    end
  end

endmodule

// File: rtl/cic8_interp.sv
// Third-order CIC interpolator, R=8, M=1, unity overall gain.
// One DW-bit sample enters every eighth enb; one DW-bit sample leaves per enb.
//   clk, rst_n  : clock, async active-low reset
//   enb         : output-rate strobe, one clk wide; block idles when low
//   din         : low-rate input, sampled on phase-0 enb
//   din_ack     : one-clk pulse the cycle after din is consumed
//   dout        : interpolated output, held between updates
//   dout_valid  : one-clk pulse marking a new dout
module cic8_interp
  import cic8_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enb,
  input  logic signed [DW-1:0] din,
  output logic                 din_ack,
  output logic signed [DW-1:0] dout,
  output logic                 dout_valid
);

  logic [PW-1:0] ph;
  acc_t          i1, i2, i3;

  acc_t          x_c, c1_c, c2_c, c3_c;
  acc_t          u_c, i1_n_c, i2_n_c, i3_n_c;
  logic          ph0_c, load_c;

  // Sign-extend the input sample into the growth width.
  assign x_c    = {{(GW-DW){din[DW-1]}}, din};
  assign ph0_c  = (ph == '0);
  assign load_c = enb & ph0_c;

  // Comb chain runs at the low rate: delays advance only on phase-0 strobes.
  cic_comb_stage u_comb1 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_c),
    .x     (x_c),
    .y_c   (c1_c)
  );

  cic_comb_stage u_comb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_c),
    .x     (c1_c),
    .y_c   (c2_c)
  );

  cic_comb_stage u_comb3 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_c),
    .x     (c2_c),
    .y_c   (c3_c)
  );

  // Zero-stuffing followed by the integrator cascade; each stage consumes
  // the freshly updated value of the stage before it.
  always_comb begin
    u_c = '0;
    if (ph0_c) begin
      u_c = c3_c;
    end
    i1_n_c = i1 + u_c;
    i2_n_c = i2 + i1_n_c;
    i3_n_c = i3 + i2_n_c;
  end

  // Phase counter, integrator state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph         <= '0;
      i1         <= '0;
      i2         <= '0;
      i3         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      din_ack    <= 1'b0;
    end else begin
      dout_valid <= enb;
      din_ack    <= load_c;
      if (enb) begin
        ph   <= ph + PW'(1);
        i1   <= i1_n_c;
        i2   <= i2_n_c;
        i3   <= i3_n_c;
        dout <= sat_dw(i3_n_c);
      end
    end
  end

endmodule

// File: tb/tb_cic8_interp.sv
// Self-checking bench for cic8_interp. The reference is a direct convolution
// of the zero-stuffed input stream with the boxcar^3 impulse response,
// scaled by 1/64 with floor rounding and clamped to 16 bits.
module tb_cic8_interp;

  logic               clk;
  logic               rst_n;
  logic               enb;
  logic signed [15:0] din;
  logic               din_ack;
  logic signed [15:0] dout;
  logic               dout_valid;

  cic8_interp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enb        (enb),
    .din        (din),
    .din_ack    (din_ack),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int h[22];
  int xs[$];
  int n_step = 0;
  int exp_dout = 0;
  int exp_valid = 0;
  int exp_ack = 0;
  int got[$];
  int ref_q[$];
  int n_valid = 0;
  int n_ack = 0;
  logic signed [15:0] rnd[8];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference model and per-cycle compare.
  always @(posedge clk) begin
    int acc;
    int j;
    if (!rst_n) begin
      n_step = 0;
      xs.delete();
      exp_dout = 0;
      exp_valid = 0;
      exp_ack = 0;
    end else if (enb) begin
      if (n_step % 8 == 0) xs.push_back(int'($signed(din)));
      acc = 0;
      foreach (xs[k]) begin
        j = n_step - 8 * k;
        if (j >= 0 && j < 22) acc += h[j] * xs[k];
      end
      exp_dout  = sat16(acc >>> 6);
      exp_valid = 1;
      exp_ack   = (n_step % 8 == 0) ? 1 : 0;
      n_step++;
    end else begin
      exp_valid = 0;
      exp_ack   = 0;
    end
    #1;
    chk("dout", int'(dout), exp_dout);
    chk("dout_valid", int'(dout_valid), exp_valid);
    chk("din_ack", int'(din_ack), exp_ack);
    if (dout_valid) got.push_back(int'(dout));
    if (dout_valid) n_valid++;
    if (din_ack) n_ack++;
  end

  function automatic logic signed [15:0] sample(input int mode, input int k);
    case (mode)
      0:       return (k == 0) ? 16'sd64 : 16'sd0;
      1:       return 16'sd64;
      2:       return (k % 2 == 0) ? 16'sd32767 : -16'sd32768;
      default: return rnd[k % 8];
    endcase
  endfunction

  // gapmode: 0 = every 20 clk, 1 = random 1..40 clk, 2 = back-to-back
  task automatic run(input int mode, input int nsteps, input int gapmode);
    int g;
    for (int s = 0; s < nsteps; s++) begin
      if (s % 8 == 0) din = sample(mode, s / 8);
      enb = 1'b1;
      @(negedge clk);
      enb = 1'b0;
      g = (gapmode == 0) ? 20 : (gapmode == 1) ? int'($urandom_range(1, 40)) : 1;
      repeat (g - 1) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got.delete();
    n_valid = 0;
    n_ack = 0;
  endtask

  initial begin
    int box[8];
    int t2[15];
    int imp[24];
    int mono;
    int maxv;

    rst_n = 1'b0;
    enb   = 1'b0;
    din   = '0;

    // Impulse response of three cascaded length-8 boxcars.
    foreach (box[i]) box[i] = 1;
    foreach (t2[i]) t2[i] = 0;
    foreach (h[i]) h[i] = 0;
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) t2[a + b] += box[a] * box[b];
    for (int a = 0; a < 15; a++)
      for (int b = 0; b < 8; b++) h[a + b] += t2[a] * box[b];

    imp = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48, 48,
            46, 42, 36, 28, 21, 15, 10, 6, 3, 1, 0, 0};

    repeat (3) @(negedge clk);
    chk("reset_dout", int'(dout), 0);
    chk("reset_valid", int'(dout_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse
    got.delete(); n_valid = 0; n_ack = 0;
    run(0, 32, 0);
    for (int i = 0; i < 24; i++) chk("impulse", got[i], imp[i]);
    for (int i = 24; i < 32; i++) chk("impulse_tail", got[i], 0);
    chk("impulse_valid_count", n_valid, 32);
    chk("impulse_ack_count", n_ack, 4);

    // Step
    do_reset();
    run(1, 40, 0);
    mono = 1;
    maxv = got[0];
    for (int i = 1; i < 40; i++) begin
      if (got[i] < got[i - 1]) mono = 0;
      if (got[i] > maxv) maxv = got[i];
    end
    chk("step_out22", got[21], 64);
    chk("step_out40", got[39], 64);
    chk("step_monotonic", mono, 1);
    chk("step_max", maxv, 64);

    // Full-scale alternating input
    do_reset();
    run(2, 48, 0);
    chk("fullscale_valid_count", n_valid, 48);

    // Strobe gaps: fixed 20 vs random jitter
    foreach (rnd[i]) rnd[i] = 16'($urandom);
    do_reset();
    run(3, 48, 0);
    ref_q = got;
    do_reset();
    run(3, 48, 1);
    for (int i = 0; i < 48; i++) chk("gap_seq", got[i], ref_q[i]);
    chk("gap_valid_count", n_valid, 48);
    chk("gap_ack_count", n_ack, 6);

    // Reset mid-stream at ph=5 during a step
    do_reset();
    run(1, 13, 0);
    chk("pre_reset_nonzero", (dout != 0) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", int'(dout), 0);
    chk("midrst_valid", int'(dout_valid), 0);
    chk("midrst_ack", int'(din_ack), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got.delete(); n_valid = 0; n_ack = 0;
    run(1, 16, 0);
    chk("restart_0", got[0], 1);
    chk("restart_1", got[1], 3);
    chk("restart_2", got[2], 6);

    // Back-to-back strobes vs spaced golden
    foreach (rnd[i]) rnd[i] = 16'($urandom);
    do_reset();
    run(3, 24, 0);
    ref_q = got;
    do_reset();
    run(3, 24, 2);
    for (int i = 0; i < 24; i++) chk("b2b_seq", got[i], ref_q[i]);
    chk("b2b_valid_count", n_valid, 24);
    chk("b2b_ack_count", n_ack, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
